subtractor_serial: RTL and testbench
====================================

Name: subtractor_serial

Overview:
- Multi-cycle, bit-serial subtractor; the inverse operation of the ripple-carry adder family.
- Computes inA - inB - inBorrow one bit per clock, LSB first, using a single registered borrow.
- Used where area matters more than latency. Start/done handshake; operands captured at start.

Parameters:
- WIDTH, 4, operand and result width in bits (>= 2).

Ports:
- inClock  input  1  rising-edge clock
- inResetN  input  1  asynchronous active-low reset
- inStart  input  1  request new operation; sampled only in IDLE
- inA  input  WIDTH  minuend, captured on accepted start
- inB  input  WIDTH  subtrahend, captured on accepted start
- inBorrow  input  1  initial borrow-in, captured on accepted start
- outBusy  output  1  high whenever state is not IDLE
- outDone  output  1  one-cycle pulse, result valid
- outDiff  output  WIDTH  difference (inA - inB - inBorrow) mod 2^WIDTH
- outBorrow  output  1  final borrow-out; 1 iff inA < inB + inBorrow (unsigned)

Behaviour:
- Reset (inResetN=0, async):
  - state=IDLE.
  - outBusy, outDone, outDiff and outBorrow all 0.
  - Internal operand, shift and counter registers all 0.
  - Reset may assert in any state. An in-flight operation is discarded, no outDone is produced, and nothing resumes after release.
- States: IDLE, RUN, DONE.
- IDLE:
  - If inStart=1 at edge E0: latch inA, inB and inBorrow into working registers, bit counter=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN: each edge processes bit i = counter, using a=A[i], b=B[i] and br=borrow register.
  - d = a ^ b ^ br
  - br_next = (~a & b) | (~(a ^ b) & br)
  - d is shifted into an internal result shift register at the MSB (right shift). After WIDTH bits, bit 0 holds the LSB result.
  - Counter increments by 1 per edge.
  - On the edge processing bit WIDTH-1 (edge E0+WIDTH): load outDiff from the completed shift value, load outBorrow from the final br_next, go to DONE.
- DONE:
  - outDone=1 for exactly this one cycle.
  - Next edge returns to IDLE unconditionally.
- Latency: outDone is high in the cycle following edge E0+WIDTH, i.e. WIDTH clocks after the start edge. Throughput is one operation per WIDTH+2 cycles.
- outDiff and outBorrow:
  - Change only on DONE entry and on reset.
  - Hold their value through IDLE and through the next RUN until the next DONE entry.
- inStart handling:
  - Ignored in RUN and DONE; no queuing.
  - inStart held continuously high starts a new operation on the first IDLE edge after DONE.
- Changes on inA, inB or inBorrow after the start edge have no effect on the operation in flight.
- Width rules:
  - All arithmetic is unsigned, modulo 2^WIDTH.
  - outBorrow is the borrow out of bit WIDTH-1.
  - No overflow flag; signed interpretation is left to the consumer.

Test Plan:
- WIDTH=4; inA=0111, inB=0010, inBorrow=0; start pulse -> outBusy high the cycle after the start edge; outDone pulse exactly 4 clocks after the start edge; outDiff=0101, outBorrow=0.
- inA=0000, inB=0001, inBorrow=0 -> outDiff=1111, outBorrow=1. Then inA=0101, inB=0101, inBorrow=1 -> outDiff=1111, outBorrow=1.
- inA=1111, inB=0000, inBorrow=0 with inStart held high for 10 cycles -> outDiff=1111, outBorrow=0; second operation starts on the first IDLE edge after DONE; inA toggled during RUN does not change the result.
- Start inA=1001, inB=0011; assert inResetN=0 after 2 RUN cycles -> all outputs 0 immediately, no outDone; after release, state stays IDLE until the next inStart.
- Exhaustive sweep: all 256 (inA, inB) pairs x inBorrow in {0,1} -> outDiff=(inA-inB-inBorrow) mod 16 and outBorrow=(inA < inB+inBorrow) for every operation; exactly one outDone per start.

Source files
------------

// File: rtl/subtractor_serial.sv
// Bit-serial unsigned subtractor: diff = A - B - borrow_in, one bit per clock, LSB first.
// Latency: outDone pulses WIDTH clocks after the accepted start edge; one op per WIDTH+2 cycles.
// Backpressure: none; inStart is only sampled in IDLE and is ignored (not queued) while busy.
//
// Ports:
//   inClock, inResetN       rising-edge clock, asynchronous active-low reset
//   inStart                 start request, sampled in IDLE only
//   inA, inB, inBorrow      minuend, subtrahend, borrow-in (captured on accepted start)
//   outBusy                 high whenever the engine is not IDLE
//   outDone                 one-cycle pulse; outDiff/outBorrow are valid
//   outDiff, outBorrow      difference mod 2^WIDTH and borrow out of the MSB
module subtractor_serial #(
    parameter int WIDTH = 4
) (
    input  logic             inClock,
    input  logic             inResetN,
    input  logic             inStart,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             inBorrow,
    output logic             outBusy,
    output logic             outDone,
    output logic [WIDTH-1:0] outDiff,
    output logic             outBorrow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sh_reg;
    logic             br_reg;
    logic [CW-1:0]    cnt;

    logic             bit_a;
    logic             bit_b;
    logic             d_bit;
    logic             br_nxt;
    logic             last_bit;
    logic [WIDTH-1:0] sh_nxt;

    // One-bit full subtractor on the current bit position.
    always_comb begin
        bit_a    = a_reg[cnt];
        bit_b    = b_reg[cnt];
        d_bit    = bit_a ^ bit_b ^ br_reg;
        br_nxt   = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_reg);
        last_bit = (cnt == CW'(WIDTH - 1));
        // Right shift: after WIDTH insertions at the MSB, bit 0 holds the LSB result.
        sh_nxt   = {d_bit, sh_reg[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge inClock or negedge inResetN) begin
        if (!inResetN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (inStart)  state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        outBusy = (state != IDLE);
        outDone = (state == DONE);
    end

    // Datapath: operand capture, serial shift, and result registers.
    // outDiff/outBorrow are only written on DONE entry so they hold across the next run.
    always_ff @(posedge inClock or negedge inResetN) begin
        if (!inResetN) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sh_reg    <= '0;
            br_reg    <= 1'b0;
            cnt       <= '0;
            outDiff   <= '0;
            outBorrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (inStart) begin
                        a_reg  <= inA;
                        b_reg  <= inB;
                        br_reg <= inBorrow;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    sh_reg <= sh_nxt;
                    br_reg <= br_nxt;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        outDiff   <= sh_nxt;
                        outBorrow <= br_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subtractor_serial.sv
// Self-checking bench for subtractor_serial (WIDTH=4) against an arithmetic reference model.
// Latency: checks outDone timing relative to the start edge.
// Backpressure: exercises start-held, mid-run input changes and reset during a run.
module tb_subtractor_serial;

    localparam int WIDTH = 4;

    logic             inClock;
    logic             inResetN;
    logic             inStart;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             inBorrow;
    logic             outBusy;
    logic             outDone;
    logic [WIDTH-1:0] outDiff;
    logic             outBorrow;

    int errors   = 0;
    int checks   = 0;
    int starts   = 0;
    int done_cnt = 0;

    logic [WIDTH-1:0] prev_d = '0;
    logic             prev_b = 1'b0;

    subtractor_serial #(.WIDTH(WIDTH)) dut (
        .inClock   (inClock),
        .inResetN  (inResetN),
        .inStart   (inStart),
        .inA       (inA),
        .inB       (inB),
        .inBorrow  (inBorrow),
        .outBusy   (outBusy),
        .outDone   (outDone),
        .outDiff   (outDiff),
        .outBorrow (outBorrow)
    );

    initial inClock = 1'b0;
    always #5 inClock = ~inClock;

    always @(negedge inClock) begin
        if (outDone === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain unsigned arithmetic.
    function automatic logic [WIDTH-1:0] model_diff(input int a, input int b, input int bin);
        int r;
        r = (a - b - bin) % (1 << WIDTH);
        if (r < 0) r += (1 << WIDTH);
        return r[WIDTH-1:0];
    endfunction

    function automatic logic model_borrow(input int a, input int b, input int bin);
        return (a < b + bin);
    endfunction

    // One complete operation; optionally scrambles inputs right after the start edge.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic bin, input bit toggle);
        logic [WIDTH-1:0] ed;
        logic             eb;
        bit               seen;
        ed = model_diff(int'(a), int'(b), int'(bin));
        eb = model_borrow(int'(a), int'(b), int'(bin));
        @(negedge inClock);
        inA = a; inB = b; inBorrow = bin; inStart = 1'b1;
        @(posedge inClock); #1;
        inStart = 1'b0;
        starts++;
        check("busy_after_start", outBusy, 1);
        if (toggle) begin
            inA = ~a;
            inB = WIDTH'($urandom);
            inBorrow = ~bin;
        end
        seen = 0;
        for (int k = 1; k <= WIDTH + 3 && !seen; k++) begin
            @(posedge inClock); #1;
            if (outDone) begin
                seen = 1;
                check("latency", k, WIDTH);
                check("diff", outDiff, ed);
                check("borrow", outBorrow, eb);
            end else if (k < WIDTH) begin
                check("hold_diff", outDiff, prev_d);
                check("hold_borrow", outBorrow, prev_b);
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        prev_d = ed;
        prev_b = eb;
        @(posedge inClock); #1;
        check("done_one_cycle", outDone, 0);
        check("idle_after_done", outBusy, 0);
    endtask

    initial begin
        bit seen;
        bit bad;
        int gap;
        inResetN = 1'b0;
        inStart  = 1'b0;
        inA      = '0;
        inB      = '0;
        inBorrow = 1'b0;

        // Reset state
        #2;
        check("rst_busy", outBusy, 0);
        check("rst_done", outDone, 0);
        check("rst_diff", outDiff, 0);
        check("rst_borrow", outBorrow, 0);
        repeat (2) @(negedge inClock);
        inResetN = 1'b1;

        // Directed cases
        run_op(4'b0111, 4'b0010, 1'b0, 0);
        run_op(4'b0000, 4'b0001, 1'b0, 0);
        run_op(4'b0101, 4'b0101, 1'b1, 0);

        // Start held high: back-to-back ops, inA changed during the first run
        @(negedge inClock);
        inA = 4'b1111; inB = 4'b0000; inBorrow = 1'b0; inStart = 1'b1;
        @(posedge inClock); #1;
        inA = 4'b0000;
        seen = 0;
        for (int k = 1; k <= WIDTH + 3 && !seen; k++) begin
            @(posedge inClock); #1;
            if (outDone) begin
                seen = 1;
                check("held_latency", k, WIDTH);
                check("held_diff1", outDiff, 4'b1111);
                check("held_borrow1", outBorrow, 0);
            end
        end
        if (!seen) check("held_timeout1", 0, 1);
        seen = 0;
        gap = 0;
        for (int k = 1; k <= WIDTH + 6 && !seen; k++) begin
            @(posedge inClock); #1;
            if (outDone) begin
                seen = 1;
                gap = k;
            end
        end
        inStart = 1'b0;
        starts += 2;
        check("restart_gap", gap, WIDTH + 2);
        check("held_diff2", outDiff, 4'b0000);
        check("held_borrow2", outBorrow, 0);
        repeat (2) @(posedge inClock);
        #1;
        check("held_stop", outBusy, 0);
        prev_d = '0;
        prev_b = 1'b0;

        // Reset in the middle of a run: discard, no done, stays idle
        run_op(4'b0110, 4'b0001, 1'b0, 0);
        @(negedge inClock);
        inA = 4'b1001; inB = 4'b0011; inBorrow = 1'b0; inStart = 1'b1;
        @(posedge inClock); #1;
        inStart = 1'b0;
        repeat (2) @(posedge inClock);
        #2;
        inResetN = 1'b0;
        #1;
        check("midrst_busy", outBusy, 0);
        check("midrst_done", outDone, 0);
        check("midrst_diff", outDiff, 0);
        check("midrst_borrow", outBorrow, 0);
        @(negedge inClock);
        inResetN = 1'b1;
        bad = 0;
        repeat (8) begin
            @(posedge inClock); #1;
            if (outBusy || outDone) bad = 1;
        end
        check("midrst_stays_idle", bad, 0);
        prev_d = '0;
        prev_b = 1'b0;

        // Randomized operations with random gaps and mid-run input scrambling
        repeat (40) begin
            repeat ($urandom_range(0, 3)) @(negedge inClock);
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
        end

        // Exhaustive sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    run_op(a[WIDTH-1:0], b[WIDTH-1:0], c[0], 0);
                end
            end
        end

        @(negedge inClock);
        check("done_per_start", done_cnt, starts);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
